limn2600_cache_ctrl: RTL and testbench

Sequencing controller for the Limn2600 memory cache. It sits between the CPU load/store port and the external memory bus, owns the tag/valid/data arrays, and turns each CPU access into a hit, a line fill or a write-through. It also sequences invalidation at reset and on an explicit flush request. The cache is direct-mapped, write-through and no-write-allocate.

---
 rtl/limn2600_cache_pkg.sv | 29 ++
 rtl/limn2600_cache_array.sv | 57 +++++
 rtl/limn2600_cache_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_limn2600_cache_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/limn2600_cache_pkg.sv
// Shared types and address-field helpers for the Limn2600 cache controller.
// Offset and index widths assume LINES >= 2 and LINE_WORDS >= 2.
package limn2600_cache_pkg;

    localparam int DEF_LINES      = 16;
    localparam int DEF_LINE_WORDS = 4;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL,
        ST_WRITE,
        ST_DONE
    } state_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines, input int line_words);
        return 32 - 2 - $clog2(line_words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/limn2600_cache_array.sv
// Tag, valid and data storage: one synchronous read port, a word write port,
// a tag/valid set port for fill completion and a per-index valid clear.
module limn2600_cache_array
    import limn2600_cache_pkg::*;
#(
    parameter int  LINES      = DEF_LINES,
    parameter int  LINE_WORDS = DEF_LINE_WORDS,
    localparam int IDX_W      = idx_w(LINES),
    localparam int OFF_W      = off_w(LINE_WORDS),
    localparam int TAG_W      = tag_w(LINES, LINE_WORDS)
) (
    input  logic             i_clk,
    input  logic [IDX_W-1:0] i_rd_idx,
    input  logic [OFF_W-1:0] i_rd_off,
    output logic             o_rd_valid,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic [31:0]      o_rd_data,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [OFF_W-1:0] i_wr_off,
    input  logic [31:0]      i_wr_data,
    input  logic             i_set_en,
    input  logic [IDX_W-1:0] i_set_idx,
    input  logic [TAG_W-1:0] i_set_tag,
    input  logic             i_clr_en,
    input  logic [IDX_W-1:0] i_clr_idx
);

    logic [31:0]      r_data [LINES*LINE_WORDS];
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [LINES-1:0] r_valid;
    logic             r_rd_valid;
    logic [TAG_W-1:0] r_rd_tag;
    logic [31:0]      r_rd_data;

    // Valid bits have no reset: the controller flushes every line after reset.
    always_ff @(posedge i_clk) begin
        r_rd_valid <= r_valid[i_rd_idx];
        r_rd_tag   <= r_tag[i_rd_idx];
        r_rd_data  <= r_data[{i_rd_idx, i_rd_off}];
        if (i_wr_en) begin
            r_data[{i_wr_idx, i_wr_off}] <= i_wr_data;
        end
        if (i_set_en) begin
            r_valid[i_set_idx] <= 1'b1;
            r_tag[i_set_idx]   <= i_set_tag;
        end
        if (i_clr_en) begin
            r_valid[i_clr_idx] <= 1'b0;
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_tag   = r_rd_tag;
    assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/limn2600_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache sequencer between the
// CPU load/store port and the external memory bus.
module limn2600_cache_ctrl
    import limn2600_cache_pkg::*;
#(
    parameter int  LINES      = DEF_LINES,
    parameter int  LINE_WORDS = DEF_LINE_WORDS,
    localparam int IDX_W      = idx_w(LINES),
    localparam int OFF_W      = off_w(LINE_WORDS),
    localparam int TAG_W      = tag_w(LINES, LINE_WORDS)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_ready,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack
);

    state_t           r_state;
    logic [IDX_W-1:0] r_flush_idx;
    logic [OFF_W-1:0] r_fill_cnt;
    logic [31:0]      r_cpu_rdata;
    logic             r_cpu_ready;
    logic             r_busy;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;

    logic [OFF_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_rd_valid;
    logic [TAG_W-1:0] w_rd_tag;
    logic [31:0]      w_rd_data;
    logic             w_hit;
    logic             w_fill_ack;
    logic             w_fill_last;
    logic             w_wr_en;
    logic [OFF_W-1:0] w_wr_off;
    logic [31:0]      w_wr_data;
    logic             w_set_en;
    logic             w_clr_en;
    logic             w_unused_addr;

    // The requester holds the address stable for the whole access.
    assign w_off         = i_cpu_addr[OFF_W+1:2];
    assign w_idx         = i_cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign w_tag         = i_cpu_addr[31:OFF_W+IDX_W+2];
    assign w_unused_addr = ^i_cpu_addr[1:0];

    assign w_hit       = w_rd_valid && (w_rd_tag == w_tag);
    assign w_fill_ack  = (r_state == ST_FILL) && i_mem_ack;
    assign w_fill_last = (r_fill_cnt == OFF_W'(LINE_WORDS - 1));

    // Array writes are suppressed on the reset edge so an abandoned fill
    // cannot mark its line valid.
    assign w_wr_en   = !i_rst && (w_fill_ack ||
                       ((r_state == ST_LOOKUP) && i_cpu_we && w_hit));
    assign w_wr_off  = (r_state == ST_FILL) ? r_fill_cnt : w_off;
    assign w_wr_data = (r_state == ST_FILL) ? i_mem_rdata : i_cpu_wdata;
    assign w_set_en  = !i_rst && w_fill_ack && w_fill_last;
    assign w_clr_en  = (r_state == ST_FLUSH);

    limn2600_cache_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .i_clk      (i_clk),
        .i_rd_idx   (w_idx),
        .i_rd_off   (w_off),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_idx),
        .i_wr_off   (w_wr_off),
        .i_wr_data  (w_wr_data),
        .i_set_en   (w_set_en),
        .i_set_idx  (w_idx),
        .i_set_tag  (w_tag),
        .i_clr_en   (w_clr_en),
        .i_clr_idx  (r_flush_idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_FLUSH;
            r_flush_idx <= '0;
            r_fill_cnt  <= '0;
            r_cpu_rdata <= '0;
            r_cpu_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_cpu_ready <= 1'b0;
            case (r_state)
                ST_FLUSH: begin
                    r_flush_idx <= IDX_W'(r_flush_idx + 1);
                    if (r_flush_idx == IDX_W'(LINES - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    // A request still held during its own ready pulse is not a new one.
                    if (i_flush) begin
                        r_state     <= ST_FLUSH;
                        r_flush_idx <= '0;
                        r_busy      <= 1'b1;
                    end else if (i_cpu_req && !r_cpu_ready) begin
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (i_cpu_we) begin
                        r_state     <= ST_WRITE;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {i_cpu_addr[31:2], 2'b00};
                        r_mem_wdata <= i_cpu_wdata;
                    end else if (w_hit) begin
                        r_state     <= ST_IDLE;
                        r_cpu_rdata <= w_rd_data;
                        r_cpu_ready <= 1'b1;
                    end else begin
                        r_state    <= ST_FILL;
                        r_fill_cnt <= '0;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}, 2'b00};
                    end
                end
                ST_FILL: begin
                    if (i_mem_ack) begin
                        if (r_fill_cnt == w_off) begin
                            r_cpu_rdata <= i_mem_rdata;
                        end
                        if (w_fill_last) begin
                            r_state   <= ST_DONE;
                            r_mem_req <= 1'b0;
                        end else begin
                            r_fill_cnt <= OFF_W'(r_fill_cnt + 1);
                            r_mem_addr <= r_mem_addr + 32'd4;
                        end
                    end
                end
                ST_WRITE: begin
                    if (i_mem_ack) begin
                        r_state     <= ST_DONE;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_cpu_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Stores arrive with ready already raised; loads raise it here.
                    if (r_cpu_ready) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cpu_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_FLUSH;
            endcase
        end
    end

    assign o_cpu_rdata = r_cpu_rdata;
    assign o_cpu_ready = r_cpu_ready;
    assign o_busy      = r_busy;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_limn2600_cache_ctrl.sv
// Directed bench for limn2600_cache_ctrl with a latency-3 memory model and
// scoreboard queues for CPU read data and memory-bus transactions.
module tb_limn2600_cache_ctrl;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } mtx_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        flush = 1'b0;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;
    logic [1:0]  m_cnt = '0;

    int total = 0;
    int bad   = 0;

    mtx_t        log_q[$];
    mtx_t        wr_q[$];
    mtx_t        exp_mem[$];
    logic [31:0] exp_rd[$];

    limn2600_cache_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_rdata (cpu_rdata),
        .o_cpu_ready (cpu_ready),
        .i_flush     (flush),
        .o_busy      (busy),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (m_rdata),
        .i_mem_ack   (m_ack)
    );

    initial forever #5 clk = ~clk;

    // Backing store: a fixed pattern overlaid with every write seen on the bus.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] v;
        if (a[31:4] == 28'h0000123) v = 32'hA0 + {28'h0, a[3:2]};
        else                        v = a ^ 32'hC0DE_0000;
        foreach (wr_q[i]) if (wr_q[i].addr == a) v = wr_q[i].data;
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ack <= 1'b0;
            m_cnt <= '0;
        end else begin
            m_ack <= 1'b0;
            if (mem_req && !m_ack) begin
                if (m_cnt == 2'd2) begin
                    m_ack   <= 1'b1;
                    m_cnt   <= '0;
                    m_rdata <= mem_rd(mem_addr);
                    log_q.push_back({mem_addr, mem_we, mem_wdata});
                    if (mem_we) wr_q.push_back({mem_addr, 1'b1, mem_wdata});
                end else begin
                    m_cnt <= m_cnt + 2'd1;
                end
            end else begin
                m_cnt <= '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_fill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_mem.push_back({base + 32'(4 * i), 1'b0, 32'h0});
    endtask

    task automatic chk_mem(input string nm);
        chk({nm, "_mem_count"}, 32'(log_q.size()), 32'(exp_mem.size()));
        while (log_q.size() > 0 && exp_mem.size() > 0) begin
            mtx_t a;
            mtx_t b;
            a = log_q.pop_front();
            b = exp_mem.pop_front();
            chk({nm, "_mem_addr"}, a.addr, b.addr);
            chk({nm, "_mem_we"}, {31'b0, a.we}, {31'b0, b.we});
            if (b.we) chk({nm, "_mem_wdata"}, a.data, b.data);
        end
        log_q.delete();
        exp_mem.delete();
    endtask

    task automatic wait_flush(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    // One CPU access; cycle numbers count samples after the request is driven.
    task automatic access(input string nm, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic fl, input logic [31:0] exp_data,
                          output int lat, output int mreq1, output int ack_last,
                          output int busy_n);
        logic [31:0] e;
        if (!we) exp_rd.push_back(exp_data);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; flush = fl;
        lat = -1; mreq1 = -1; ack_last = -1; busy_n = 0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (busy) begin busy_n++; flush = 1'b0; end
            if (mem_req && mreq1 < 0) mreq1 = c;
            if (m_ack) ack_last = c;
            if (cpu_ready) begin lat = c; break; end
        end
        chk({nm, "_done"}, {31'b0, lat > 0}, 32'd1);
        if (!we) begin
            e = exp_rd.pop_front();
            chk({nm, "_rdata"}, cpu_rdata, e);
        end
        cpu_req = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_ready_pulse"}, {31'b0, cpu_ready}, 32'd0);
    endtask

    initial begin
        int lat, m1, al, bn, n;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_ready", {31'b0, cpu_ready}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        wait_flush(n);
        chk("init_flush_len", 32'(n), 32'd16);
        chk("idle_mem_req", {31'b0, mem_req}, 32'd0);

        push_fill(32'h1230);
        access("cold_load", 1'b0, 32'h1234, 32'h0, 1'b0, 32'hA1, lat, m1, al, bn);
        chk("cold_mreq_t", 32'(m1), 32'd2);
        chk("cold_ready_t", 32'(lat), 32'(al + 2));
        chk_mem("cold");

        access("hit_load", 1'b0, 32'h1238, 32'h0, 1'b0, 32'hA2, lat, m1, al, bn);
        chk("hit_lat", 32'(lat), 32'd2);
        chk("hit_no_mreq", 32'(m1), 32'hFFFF_FFFF);
        chk_mem("hit");

        exp_mem.push_back({32'h1234, 1'b1, 32'hDEAD});
        access("st_hit", 1'b1, 32'h1234, 32'hDEAD, 1'b0, 32'h0, lat, m1, al, bn);
        chk("st_hit_mreq_t", 32'(m1), 32'd2);
        chk("st_hit_ready_t", 32'(lat), 32'(al + 1));
        chk_mem("st_hit");

        access("ld_after_st", 1'b0, 32'h1234, 32'h0, 1'b0, 32'hDEAD, lat, m1, al, bn);
        chk("ld_after_st_lat", 32'(lat), 32'd2);
        chk("ld_after_st_no_mreq", 32'(m1), 32'hFFFF_FFFF);
        chk_mem("ld_after_st");

        exp_mem.push_back({32'h5670, 1'b1, 32'h5555});
        access("st_miss", 1'b1, 32'h5670, 32'h5555, 1'b0, 32'h0, lat, m1, al, bn);
        chk("st_miss_ready_t", 32'(lat), 32'(al + 1));
        chk_mem("st_miss");

        push_fill(32'h5670);
        access("ld_no_alloc", 1'b0, 32'h5670, 32'h0, 1'b0, 32'h5555, lat, m1, al, bn);
        chk("ld_no_alloc_mreq_t", 32'(m1), 32'd2);
        chk_mem("ld_no_alloc");

        // Flush and request raised together: the flush wins, then the load refills.
        push_fill(32'h1230);
        access("flush_req", 1'b0, 32'h1234, 32'h0, 1'b1, 32'hDEAD, lat, m1, al, bn);
        chk("flush_req_busy_len", 32'(bn), 32'd16);
        chk_mem("flush_req");

        // Reset in the middle of a fill abandons it and restarts the flush.
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_flush(n);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1234;
        n = 0;
        while (log_q.size() < 2 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        chk("rstfill_two_acks", 32'(log_q.size()), 32'd2);
        @(posedge clk); #1;
        rst = 1'b1; cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("rstfill_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rstfill_busy", {31'b0, busy}, 32'd1);
        rst = 1'b0;
        wait_flush(n);
        chk("rstfill_flush_len", 32'(n), 32'd16);
        log_q.delete();
        push_fill(32'h1230);
        access("refill", 1'b0, 32'h1234, 32'h0, 1'b0, 32'hDEAD, lat, m1, al, bn);
        chk("refill_mreq_t", 32'(m1), 32'd2);
        chk("refill_ready_t", 32'(lat), 32'(al + 2));
        chk_mem("refill");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
